// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of input words needed to cover the whole chain (last one may be partial).
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that presents its bits LSB-first; load takes priority so a new
// word can replace the buffer in the same cycle its last bit is shifted out.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_full,
  output logic              o_bit,
  output logic              o_last
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic              r_full;

  always_ff @(posedge i_ck) begin
    if (i_rst || i_clear) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_buf  <= i_data;
      r_idx  <= '0;
      r_full <= 1'b1;
    end else if (i_shift && r_full) begin
      r_buf <= r_buf >> 1;
      if (r_idx == LAST_IDX) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign o_full = r_full;
  assign o_bit  = r_buf[0];
  assign o_last = r_full && (r_idx == LAST_IDX);

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words onto a DFFSRQ chain, counts exactly CHAIN_LEN
// shifts and accumulates parity of the old chain contents falling off the tail.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              chain_head,
  output logic              shift_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int WPL  = words_per_load(CHAIN_LEN, WORD_W);
  localparam int WC_W = $clog2(WPL + 1);
  localparam logic [CNT_W-1:0] LEN_C      = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WPL_C      = WC_W'(WPL);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_parity;
  logic             r_head;
  logic [CNT_W-1:0] r_shift_cnt;
  logic [WC_W-1:0]  r_word_cnt;

  logic w_full;
  logic w_bit;
  logic w_last;
  logic w_shift;
  logic w_ready;
  logic w_accept;
  logic w_clear;

  assign w_shift  = (r_state == ST_SHIFT) && w_full && (r_shift_cnt < LEN_C);
  // Accept while the buffer is empty or just releasing its final bit: no bubble.
  assign w_ready  = (r_state == ST_SHIFT) && (r_word_cnt < WPL_C) &&
                    (!w_full || (w_last && w_shift));
  assign w_accept = w_ready && in_valid;
  assign w_clear  = (r_state != ST_SHIFT);

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .i_ck    (CK),
    .i_rst   (RST),
    .i_clear (w_clear),
    .i_load  (w_accept),
    .i_data  (in_data),
    .i_shift (w_shift),
    .o_full  (w_full),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_parity    <= 1'b0;
      r_head      <= 1'b0;
      r_shift_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_SHIFT;
            r_busy      <= 1'b1;
            r_parity    <= 1'b0;
            r_shift_cnt <= '0;
            r_word_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_accept) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
          end
          if (w_shift) begin
            r_shift_cnt <= r_shift_cnt + CNT_W'(1);
            r_parity    <= r_parity ^ chain_tail;
            r_head      <= w_bit;
            if (r_shift_cnt == LAST_SHIFT) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // On a stall the head keeps presenting the last bit shifted in.
  assign chain_head  = w_shift ? w_bit : r_head;
  assign shift_en    = w_shift;
  assign in_ready    = w_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tail_parity = r_parity;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: queue-based reference model checked every cycle,
// plus directed checks on latency, stalls, parity, reset abort and a partial last word.
module tb_ccff_chain_loader;

  localparam int N   = 64;
  localparam int W   = 8;
  localparam int WPL = 8;
  localparam int NB  = 10;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic       RST, start, in_valid, in_ready, chain_head, shift_en, busy, done, tail_parity;
  logic [7:0] in_data;
  logic       chain_tail;

  logic       rst_b, start_b, in_valid_b, in_ready_b, head_b, shift_en_b, busy_b, done_b, par_b;
  logic [7:0] in_data_b;
  logic       tail_b;

  logic [N-1:0]  chain_a;
  logic [NB-1:0] chain_b;
  logic          preload_en;
  logic [N-1:0]  preload_val;

  int total = 0;
  int bad   = 0;

  logic [7:0] wtbl [0:7];
  int first_sh, last_sh, n_sh, done_cyc, n_done;
  logic [5:0] zero_snap;
  int         zero_seen;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(N)) dut_a (
    .CK(CK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .chain_head(chain_head), .shift_en(shift_en),
    .chain_tail(chain_tail), .busy(busy), .done(done), .tail_parity(tail_parity)
  );

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(NB)) dut_b (
    .CK(CK), .RST(rst_b), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .chain_head(head_b), .shift_en(shift_en_b),
    .chain_tail(tail_b), .busy(busy_b), .done(done_b), .tail_parity(par_b)
  );

  // Behavioural chains: the first bit shifted in ends at bit 0 (the tail).
  always @(posedge CK) begin
    if (preload_en) chain_a <= preload_val;
    else if (shift_en) chain_a <= {chain_head, chain_a[N-1:1]};
  end
  always @(posedge CK) begin
    if (shift_en_b) chain_b <= {head_b, chain_b[NB-1:1]};
  end
  assign chain_tail = chain_a[0];
  assign tail_b     = chain_b[0];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: pending bits as a queue, counts of shifts/words as integers.
  task automatic compare_loop();
    bit on = 0;
    int mode = 0;
    bit q[$];
    int shifts = 0, words = 0;
    bit par = 0, head = 0;
    bit e_ready, e_shift, e_head, e_busy, e_done;
    logic [5:0] got, exp;
    forever begin
      @(negedge CK);
      e_busy  = (mode == 1);
      e_done  = (mode == 2);
      e_shift = e_busy && (q.size() > 0) && (shifts < N);
      e_ready = e_busy && (words < WPL) && ((q.size() == 0) || (q.size() == 1 && e_shift));
      e_head  = e_shift ? q[0] : head;
      if (on) begin
        got = {in_ready, shift_en, chain_head, busy, done, tail_parity};
        exp = {e_ready, e_shift, e_head, e_busy, e_done, par};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL cycle_model t=%0t rdy/sh/head/busy/done/par got %b expected %b",
                   $time, got, exp);
        end
      end
      if (RST) begin
        on = 1; mode = 0; q.delete(); shifts = 0; words = 0; par = 0; head = 0;
      end else if (on) begin
        case (mode)
          0: if (start) begin
               mode = 1; shifts = 0; words = 0; par = 0; q.delete();
             end
          1: begin
               if (e_shift) begin
                 head = q.pop_front();
                 shifts++;
                 par ^= chain_tail;
                 if (shifts == N) mode = 2;
               end
               if (e_ready && in_valid) begin
                 for (int b = 0; b < W; b++) q.push_back(in_data[b]);
                 words++;
               end
             end
          default: mode = 0;
        endcase
      end
    end
  endtask

  task automatic preload(input logic [N-1:0] v);
    preload_en = 1'b1; preload_val = v;
    @(posedge CK); #1;
    preload_en = 1'b0;
  endtask

  // One load on dut_a; cycle numbers are counted from the edge that samples start.
  task automatic run_a(input bit stall, input bit inj, input int rst_at);
    int widx = 0, gap = 0, rst_cyc = -1;
    first_sh = -1; last_sh = -1; n_sh = 0; done_cyc = -1; n_done = 0; zero_seen = 0;
    start = 1'b1; in_valid = 1'b0;
    @(posedge CK); #1;
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      in_valid = (widx < 8) && !(stall && widx == 3 && gap < 5);
      in_data  = wtbl[(widx < 8) ? widx : 7];
      start    = inj && (c == 10 || c == 66);
      RST      = (c == rst_cyc);
      @(negedge CK);
      if (shift_en) begin
        n_sh++;
        if (first_sh < 0) first_sh = c;
        last_sh = c;
      end
      if (done) begin n_done++; done_cyc = c; end
      if (stall && widx == 3 && !in_valid && in_ready) gap++;
      if (in_valid && in_ready) widx++;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        zero_snap = {in_ready, shift_en, chain_head, busy, done, tail_parity};
        zero_seen = 1;
      end
      if (rst_at > 0 && n_sh == rst_at && rst_cyc < 0) rst_cyc = c + 1;
      @(posedge CK); #1;
      if (rst_at == 0 && done_cyc > 0 && c >= done_cyc + 3) break;
      if (rst_at > 0 && rst_cyc > 0 && c >= rst_cyc + 20) break;
    end
    start = 1'b0; in_valid = 1'b0; RST = 1'b0;
  endtask

  initial begin
    int n_hs_b, n_sh_b, rdy_after, done_b_cyc, bidx;
    for (int i = 0; i < 8; i++) wtbl[i] = 8'(i + 1);
    RST = 1'b1; rst_b = 1'b1; start = 0; in_valid = 0; in_data = '0;
    start_b = 0; in_valid_b = 0; in_data_b = '0; preload_en = 0; preload_val = '0;
    fork compare_loop(); join_none
    repeat (3) @(posedge CK);
    #1 RST = 1'b0; rst_b = 1'b0;
    @(negedge CK);
    check("reset_outputs", {in_ready, shift_en, chain_head, busy, done, tail_parity}, 0);
    check("reset_outputs_b", {in_ready_b, shift_en_b, head_b, busy_b, done_b, par_b}, 0);
    @(posedge CK); #1;

    // Back-to-back load with ignored starts during SHIFT and DONE
    preload('0);
    run_a(1'b0, 1'b1, 0);
    check("b2b_first_shift", first_sh, 2);
    check("b2b_last_shift", last_sh, 65);
    check("b2b_shift_count", n_sh, 64);
    check("b2b_done_cycle", done_cyc, 66);
    check("b2b_done_pulses", n_done, 1);
    check("b2b_chain", chain_a, 64'h0807060504030201);
    check("b2b_parity_zero_chain", tail_parity, 0);
    check("b2b_busy_after", busy, 0);

    // Tail parity over old contents
    preload('1);
    run_a(1'b0, 1'b0, 0);
    check("parity_all_ones", tail_parity, 0);
    preload(64'h0000_0100_0000_0000);
    run_a(1'b0, 1'b0, 0);
    check("parity_single_one", tail_parity, 1);
    check("parity_run_chain", chain_a, 64'h0807060504030201);

    // Five-cycle gap in in_valid after word 3
    run_a(1'b1, 1'b0, 0);
    check("stall_shift_count", n_sh, 64);
    check("stall_last_shift", last_sh, 70);
    check("stall_done_cycle", done_cyc, 71);
    check("stall_chain", chain_a, 64'h0807060504030201);

    // Reset mid-load, then a clean load
    run_a(1'b0, 1'b0, 30);
    check("rst_zero_seen", zero_seen, 1);
    check("rst_outputs_zero", zero_snap, 0);
    check("rst_no_done", n_done, 0);
    preload('0);
    run_a(1'b0, 1'b0, 0);
    check("after_rst_shift_count", n_sh, 64);
    check("after_rst_done_cycle", done_cyc, 66);
    check("after_rst_chain", chain_a, 64'h0807060504030201);

    // Partial last word on the 10-bit chain
    n_hs_b = 0; n_sh_b = 0; rdy_after = 0; done_b_cyc = -1; bidx = 0;
    start_b = 1'b1;
    @(posedge CK); #1;
    start_b = 1'b0;
    for (int c = 1; c < 40; c++) begin
      in_valid_b = 1'b1;
      in_data_b  = (bidx == 0) ? 8'hFF : (bidx == 1) ? 8'h02 : 8'hAA;
      @(negedge CK);
      if (shift_en_b) n_sh_b++;
      if (done_b) done_b_cyc = c;
      if (in_valid_b && in_ready_b) begin n_hs_b++; bidx++; end
      else if (bidx >= 2 && in_ready_b) rdy_after++;
      @(posedge CK); #1;
      if (done_b_cyc > 0 && c >= done_b_cyc + 2) break;
    end
    in_valid_b = 1'b0;
    check("partial_handshakes", n_hs_b, 2);
    check("partial_shifts", n_sh_b, 10);
    check("partial_ready_after", rdy_after, 0);
    check("partial_chain", chain_b, 10'h2FF);
    check("partial_done_cycle", done_b_cyc, 12);

    repeat (2) @(posedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
